// File: rtl/run_det_pkg.sv
// Shared types and helpers for the run-length detector: state encoding and threshold mapping.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package run_det_pkg;

    // Width used by eff_thresh; callers zero-extend into it and truncate the result back.
    localparam int THRESH_MAX_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        COUNT  = 2'b01,
        DETECT = 2'b10
    } state_t;

    // A threshold of zero would make detection meaningless, so it behaves as one.
    function automatic logic [THRESH_MAX_W-1:0] eff_thresh(input logic [THRESH_MAX_W-1:0] th);
        return (th == '0) ? {{(THRESH_MAX_W-1){1'b0}}, 1'b1} : th;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones, never wraps.
// Latency: q updates one cycle after inc/clr is sampled.
// Backpressure: none; inc is simply ignored once saturated.
// Ports: clk, reset_n (sync active-low), clr (sync clear, beats inc), inc, q.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (inc && (r_q != '1)) begin
            r_q <= r_q + ONE;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/run_length_detector.sv
// Detects thresh consecutive samples equal to polarity; level flag, entry strobe, run length, event count.
// Latency: out/start_pulse rise the cycle after the edge that samples the t-th match; no comb path from in.
// Backpressure: en low freezes all state; start_pulse is forced low on held cycles.
// Ports: clk, reset_n (sync active-low), en, in, polarity, thresh, clear -> out, start_pulse, run_len, evt_cnt.
module run_length_detector
    import run_det_pkg::*;
#(
    parameter int CNT_W = 4,
    parameter int EVT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             in,
    input  logic             polarity,
    input  logic [CNT_W-1:0] thresh,
    input  logic             clear,
    output logic             out,
    output logic             start_pulse,
    output logic [CNT_W-1:0] run_len,
    output logic [EVT_W-1:0] evt_cnt
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_next;
    logic             r_start;
    logic             w_match;
    logic             w_enter;
    logic [CNT_W-1:0] w_t;
    logic [CNT_W-1:0] w_run_len;
    logic [CNT_W-1:0] w_run_inc;

    assign w_match   = (in == polarity);
    assign w_t       = CNT_W'(eff_thresh(THRESH_MAX_W'(thresh)));
    // Length the run will have after this sample if it matches; compared against t so that
    // lowering thresh mid-run takes effect on the very next match.
    assign w_run_inc = (w_run_len == '1) ? w_run_len : (w_run_len + ONE);
    assign w_enter   = en && (r_state != DETECT) && (w_next == DETECT);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_start <= 1'b0;
        end else if (clear) begin
            r_state <= IDLE;
            r_start <= 1'b0;
        end else begin
            if (en) begin
                r_state <= w_next;
            end
            r_start <= w_enter;
        end
    end

    always_comb begin
        w_next = r_state;
        out    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_match) begin
                    w_next = (w_t == ONE) ? DETECT : COUNT;
                end else begin
                    w_next = IDLE;
                end
            end
            COUNT: begin
                if (w_match) begin
                    w_next = (w_run_inc >= w_t) ? DETECT : COUNT;
                end else begin
                    w_next = IDLE;
                end
            end
            DETECT: begin
                out    = 1'b1;
                w_next = w_match ? DETECT : IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Run length: any enabled mismatch restarts the run; saturation is handled by the counter.
    sat_counter #(.W(CNT_W)) u_run_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (clear | (en & ~w_match)),
        .inc     (en & w_match),
        .q       (w_run_len)
    );

    sat_counter #(.W(EVT_W)) u_evt_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (clear),
        .inc     (w_enter),
        .q       (evt_cnt)
    );

    assign run_len     = w_run_len;
    assign start_pulse = r_start;

endmodule

// File: tb/tb_run_length_detector.sv
module tb_run_length_detector;

    logic       clk = 1'b0;
    logic       reset_n, en, in_b, polarity, clear;
    logic [3:0] thresh;

    logic       out_a, sp_a, out_b, sp_b;
    logic [3:0] rl_a, rl_b;
    logic [7:0] ev_a;
    logic [1:0] ev_b;

    int vecs = 0;
    int errs = 0;

    // Reference model: count of consecutive matches, whether a detection is active,
    // total detections (unbounded) and whether this cycle is the first detected one.
    int m_run = 0;
    int m_evt = 0;
    bit m_act = 0;
    bit m_pulse = 0;

    logic       exp_out, exp_sp;
    logic [3:0] exp_rl;
    logic [7:0] exp_e8;
    logic [1:0] exp_e2;

    always #5 clk = ~clk;

    run_length_detector #(.CNT_W(4), .EVT_W(8)) dut_a (
        .clk(clk), .reset_n(reset_n), .en(en), .in(in_b), .polarity(polarity),
        .thresh(thresh), .clear(clear), .out(out_a), .start_pulse(sp_a),
        .run_len(rl_a), .evt_cnt(ev_a)
    );

    run_length_detector #(.CNT_W(4), .EVT_W(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .en(en), .in(in_b), .polarity(polarity),
        .thresh(thresh), .clear(clear), .out(out_b), .start_pulse(sp_b),
        .run_len(rl_b), .evt_cnt(ev_b)
    );

    // Drive one sample, advance the model over the edge, sample outputs 1ns later.
    task automatic step(input logic s_rst_n, input logic s_clr, input logic s_en, input logic s_in);
        int t;
        reset_n = s_rst_n;
        clear   = s_clr;
        en      = s_en;
        in_b    = s_in;
        @(posedge clk);
        t = (thresh == 4'd0) ? 1 : int'(thresh);
        if (!s_rst_n || s_clr) begin
            m_run = 0; m_act = 0; m_evt = 0; m_pulse = 0;
        end else if (!s_en) begin
            m_pulse = 0;
        end else if (s_in == polarity) begin
            if (m_run < 1000) m_run++;
            m_pulse = 0;
            if (!m_act && ((m_run > 15 ? 15 : m_run) >= t)) begin
                m_act = 1; m_pulse = 1;
                if (m_evt < 1000) m_evt++;
            end
        end else begin
            m_run = 0; m_act = 0; m_pulse = 0;
        end
        exp_out = m_act;
        exp_sp  = m_pulse;
        exp_rl  = (m_run > 15)  ? 4'd15   : 4'(m_run);
        exp_e8  = (m_evt > 255) ? 8'hFF   : 8'(m_evt);
        exp_e2  = (m_evt > 3)   ? 2'd3    : 2'(m_evt);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1)));
            vecs++;
            if ({out_a, sp_a, rl_a, ev_a, out_b, sp_b, rl_b, ev_b} !== 22'd0) begin
                errs++;
                $display("FAIL reset[%0d]: got a=%b/%b/%0d/%0d b=%b/%b/%0d/%0d, want all zero",
                         i, out_a, sp_a, rl_a, ev_a, out_b, sp_b, rl_b, ev_b);
            end
        end
    endtask

    task automatic test_basic();
        logic       seq [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic       e_o [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic       e_s [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [3:0] e_r [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
        polarity = 1'b1; thresh = 4'd2;
        step(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'b1, seq[i]);
            vecs++;
            if ({out_a, sp_a, rl_a} !== {e_o[i], e_s[i], e_r[i]}) begin
                errs++;
                $display("FAIL basic[%0d]: got out=%b sp=%b rl=%0d, want out=%b sp=%b rl=%0d",
                         i, out_a, sp_a, rl_a, e_o[i], e_s[i], e_r[i]);
            end
        end
        vecs++;
        if (ev_a !== 8'd1) begin
            errs++;
            $display("FAIL basic_evt: got %0d, want 1", ev_a);
        end
    endtask

    task automatic test_thresh0();
        logic seq [3] = '{1'b1, 1'b0, 1'b1};
        logic e_o [3] = '{1'b0, 1'b1, 1'b0};
        polarity = 1'b0; thresh = 4'd0;
        step(1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b1, seq[i]);
            vecs++;
            if ({out_a, sp_a} !== {e_o[i], e_o[i]}) begin
                errs++;
                $display("FAIL thresh0[%0d]: got out=%b sp=%b, want out=%b sp=%b",
                         i, out_a, sp_a, e_o[i], e_o[i]);
            end
        end
        vecs++;
        if (ev_a !== 8'd1) begin
            errs++;
            $display("FAIL thresh0_evt: got %0d, want 1", ev_a);
        end
    endtask

    task automatic test_saturation();
        int pulses = 0;
        polarity = 1'b1; thresh = 4'd15;
        step(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, 1'b1, 1'b1);
            if (sp_a) pulses++;
            vecs++;
            if ({out_a, rl_a} !== {(i >= 14), 4'((i >= 14) ? 15 : i + 1)}) begin
                errs++;
                $display("FAIL saturate[%0d]: got out=%b rl=%0d, want out=%b rl=%0d",
                         i, out_a, rl_a, (i >= 14), (i >= 14) ? 15 : i + 1);
            end
        end
        vecs++;
        if (pulses != 1 || ev_a !== 8'd1) begin
            errs++;
            $display("FAIL saturate_evt: got pulses=%0d evt=%0d, want pulses=1 evt=1", pulses, ev_a);
        end
    endtask

    task automatic test_enable();
        logic [3:0] e_r [7] = '{4'd1, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd3};
        logic       e_o [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        polarity = 1'b1; thresh = 4'd3;
        step(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            if (i < 2 || i == 6) step(1'b1, 1'b0, 1'b1, 1'b1);
            else                 step(1'b1, 1'b0, 1'b0, 1'(i[0]));
            vecs++;
            if ({out_a, sp_a, rl_a} !== {e_o[i], e_o[i], e_r[i]}) begin
                errs++;
                $display("FAIL enable[%0d]: got out=%b sp=%b rl=%0d, want out=%b sp=%b rl=%0d",
                         i, out_a, sp_a, rl_a, e_o[i], e_o[i], e_r[i]);
            end
        end
        vecs++;
        if (ev_a !== 8'd1) begin
            errs++;
            $display("FAIL enable_evt: got %0d, want 1", ev_a);
        end
    endtask

    // Five runs of two ones: the 2-bit counter saturates; then clear in DETECT, then reset mid-run.
    task automatic test_clear_and_evt_sat();
        logic [1:0] e_e2 [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        polarity = 1'b1; thresh = 4'd2;
        step(1'b0, 1'b0, 1'b1, 1'b0);
        for (int r = 0; r < 5; r++) begin
            step(1'b1, 1'b0, 1'b1, 1'b1);
            step(1'b1, 1'b0, 1'b1, 1'b1);
            vecs++;
            if ({sp_b, ev_b, sp_a, ev_a} !== {1'b1, e_e2[r], 1'b1, 8'(r + 1)}) begin
                errs++;
                $display("FAIL evt_sat[%0d]: got sp_b=%b evt_b=%0d sp_a=%b evt_a=%0d, want 1/%0d/1/%0d",
                         r, sp_b, ev_b, sp_a, ev_a, e_e2[r], r + 1);
            end
            if (r < 4) step(1'b1, 1'b0, 1'b1, 1'b0);
        end
        step(1'b1, 1'b1, 1'b1, 1'b1);
        vecs++;
        if ({out_a, sp_a, rl_a, ev_a} !== 14'd0) begin
            errs++;
            $display("FAIL clear: got out=%b sp=%b rl=%0d evt=%0d, want all zero", out_a, sp_a, rl_a, ev_a);
        end
        step(1'b1, 1'b0, 1'b1, 1'b1);
        vecs++;
        if ({out_a, rl_a} !== {1'b0, 4'd1}) begin
            errs++;
            $display("FAIL clear_rerun: got out=%b rl=%0d, want out=0 rl=1", out_a, rl_a);
        end
        step(1'b0, 1'b0, 1'b1, 1'b1);
        vecs++;
        if ({out_a, sp_a, rl_a, ev_a, out_b, sp_b, rl_b, ev_b} !== 22'd0) begin
            errs++;
            $display("FAIL reset_mid: got a=%b/%b/%0d/%0d b=%b/%b/%0d/%0d, want all zero",
                     out_a, sp_a, rl_a, ev_a, out_b, sp_b, rl_b, ev_b);
        end
    endtask

    task automatic test_random();
        polarity = 1'b1; thresh = 4'd3;
        step(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) polarity = ~polarity;
            if ($urandom_range(0, 19) == 0) thresh = 4'($urandom_range(0, 15));
            step(($urandom_range(0, 99) != 0), ($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 3) != 0) ? polarity : ~polarity);
            vecs++;
            if ({out_a, sp_a, rl_a, ev_a} !== {exp_out, exp_sp, exp_rl, exp_e8}) begin
                errs++;
                $display("FAIL random_a[%0d]: got %b/%b/%0d/%0d, want %b/%b/%0d/%0d",
                         i, out_a, sp_a, rl_a, ev_a, exp_out, exp_sp, exp_rl, exp_e8);
            end
            vecs++;
            if ({out_b, sp_b, rl_b, ev_b} !== {exp_out, exp_sp, exp_rl, exp_e2}) begin
                errs++;
                $display("FAIL random_b[%0d]: got %b/%b/%0d/%0d, want %b/%b/%0d/%0d",
                         i, out_b, sp_b, rl_b, ev_b, exp_out, exp_sp, exp_rl, exp_e2);
            end
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        en       = 1'b0;
        in_b     = 1'b0;
        polarity = 1'b1;
        thresh   = 4'd2;
        clear    = 1'b0;
        test_reset();
        test_basic();
        test_thresh0();
        test_saturation();
        test_enable();
        test_clear_and_evt_sat();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
